clk_monitor: RTL and testbench
==============================

CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of period counter and period_o.
REQ-002 Parameter EXP_PERIOD, default 10: expected mon_clk period, in clk cycles.
REQ-003 Parameter TOL, default 1: allowed deviation from EXP_PERIOD, in clk cycles.
REQ-004 Parameter TIMEOUT, default 1024: clk cycles without a mon_clk rising edge before mon_clk is declared stopped.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mon_clk  input  1  monitored clock, asynchronous to clk.
REQ-008 en  input  1  measurement enable, synchronous to clk.
REQ-009 clr  input  1  single-cycle clear of sticky err.
REQ-010 period  output  CNT_W  last measured mon_clk period, in clk cycles.
REQ-011 valid  output  1  single-cycle pulse; period updated this cycle.
REQ-012 stopped  output  1  level; mon_clk has been absent for TIMEOUT cycles.
REQ-013 err  output  1  sticky; a measured period fell outside EXP_PERIOD±TOL.

Function
REQ-014 mon_clk SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector; an edge sampled at clk edge N SHALL produce edge detection (edge_det) in cycle N+2.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE, STOPPED.
REQ-016 IDLE: counter held at 0; en=1 -> ARM.
REQ-017 ARM: waits for the first edge_det, with no valid pulse; edge_det -> MEASURE with counter=0; counter reaching TIMEOUT-1 -> STOPPED.
REQ-018 MEASURE: counter increments each cycle without edge_det; on edge_det, period <= counter+1, valid=1 the next cycle (N+3), and counter <= 0.
REQ-019 MEASURE: counter reaching TIMEOUT-1 without edge_det -> STOPPED and stopped=1 from the next cycle.
REQ-020 If edge_det and the timeout condition coincide, edge_det SHALL win: measurement taken, no transition to STOPPED.
REQ-021 STOPPED: stopped held at 1; next edge_det -> MEASURE with counter=0, stopped=0 and no valid pulse, since the first edge after a stop only re-arms.
REQ-022 The counter SHALL saturate at 2^CNT_W-1, never wrap; period SHALL report the saturated value.
REQ-023 On each valid, err SHALL be set if period < EXP_PERIOD-TOL or period > EXP_PERIOD+TOL, with bounds clamped to 0 and 2^CNT_W-1.
REQ-024 err SHALL clear on clr; if clr and a new violation coincide, err SHALL remain 1.
REQ-025 en=0 in any state -> IDLE next cycle, counter=0 and stopped=0; period and err SHALL hold their values.
REQ-026 The synchronizer SHALL run regardless of en, so that re-enabling does not produce a spurious edge from stale data.

Reset
REQ-027 rst=1 SHALL asynchronously force: FSM=IDLE, synchronizer flops=0, edge register=0, counter=0, period=0, valid=0, stopped=0, err=0.
REQ-028 Reset mid-measurement SHALL discard the partial count; the first measurement after reset release SHALL occur at the second detected edge.

Structure
REQ-029 The FSM state enum and default constants (CNT_W, EXP_PERIOD, TOL, TIMEOUT) SHALL live in shared package clk_monitor_pkg.
REQ-030 The synchronizer plus edge detector SHALL be a sub-module, sync_edge_det, with ports clk, rst, d, rise.
REQ-031 clk_monitor SHALL contain one FSM, one counter, and the output registers; no other clocks are used.

Verification
REQ-032 mon_clk period = 10 clk cycles, en=1 -> first valid after the second edge, then valid every 10 cycles with period=10, err=0.
REQ-033 mon_clk period = 14, EXP_PERIOD=10, TOL=1 -> period=14 and err=1 after the first valid; clr -> err=0, then err=1 again at the next valid.
REQ-034 mon_clk held low, TIMEOUT=64 -> stopped=1 exactly 64+1 cycles after the last edge_det; restart mon_clk -> stopped=0 at the first edge_det, no valid, then valid one period later.
REQ-035 rst pulsed mid-period -> all outputs 0 immediately; the next valid only after two fresh edges.
REQ-036 en dropped and raised while mon_clk runs -> period and err held during IDLE, no valid until two edges after re-enable.
REQ-037 TIMEOUT set so edge_det lands on counter=TIMEOUT-1 -> valid with period=TIMEOUT, stopped stays 0.

Source files
------------

// File: rtl/clk_monitor_pkg.sv
// Shared types, default parameters and a clamp helper for the clock monitor.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    STOPPED
  } state_e;

  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_EXP_PERIOD = 10;
  localparam int unsigned DEF_TOL        = 1;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  function automatic longint clamp_range(input longint v, input longint hi);
    if (v < 0)       return 0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/clk_monitor.sv
// Measures the period of mon_clk in clk cycles, flags out-of-tolerance periods
// and detects a stopped mon_clk.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stopped,
  output logic             err
);

  localparam longint MAX_V   = (longint'(1) << CNT_W) - 1;
  localparam longint LO_RAW  = longint'(EXP_PERIOD) - longint'(TOL);
  localparam longint HI_RAW  = longint'(EXP_PERIOD) + longint'(TOL);
  localparam longint TO_RAW  = longint'(TIMEOUT) - 1;
  localparam logic [CNT_W-1:0] LO_B    = CNT_W'(clamp_range(LO_RAW, MAX_V));
  localparam logic [CNT_W-1:0] HI_B    = CNT_W'(clamp_range(HI_RAW, MAX_V));
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(clamp_range(TO_RAW, MAX_V));
  // A timeout beyond the counter range can never be reached; the counter saturates instead.
  localparam logic             TO_OK   = (TO_RAW >= 0) && (TO_RAW <= MAX_V);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stopped_q, stopped_d;
  logic             err_q, err_d;

  logic             edge_det;
  logic [CNT_W-1:0] cnt_inc;
  logic             to_hit;

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (mon_clk),
    .rise (edge_det)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign to_hit  = TO_OK && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stopped_d = stopped_q;
    err_d     = err_q & ~clr;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      stopped_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM, MEASURE: begin
          // edge_det takes priority over the timeout on the same cycle
          if (edge_det) begin
            state_d = MEASURE;
            cnt_d   = '0;
            if (state_q == MEASURE) begin
              period_d = cnt_inc;
              valid_d  = 1'b1;
              if ((cnt_inc < LO_B) || (cnt_inc > HI_B)) err_d = 1'b1;
            end
          end else if (to_hit) begin
            state_d   = STOPPED;
            cnt_d     = '0;
            stopped_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STOPPED: begin
          cnt_d = '0;
          if (edge_det) begin
            state_d   = MEASURE;
            stopped_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stopped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stopped_q <= stopped_d;
      err_q     <= err_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign stopped = stopped_q;
  assign err     = err_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed self-checking bench for clk_monitor (main instance plus a narrow-counter instance).
module tb_clk_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_clk = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;

  logic [15:0] period;
  logic        valid, stopped, err;
  logic [3:0]  period_b;
  logic        valid_b, stopped_b, err_b;

  clk_monitor #(.CNT_W(16), .EXP_PERIOD(10), .TOL(1), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .mon_clk(mon_clk), .en(en), .clr(clr),
    .period(period), .valid(valid), .stopped(stopped), .err(err)
  );

  clk_monitor #(.CNT_W(4), .EXP_PERIOD(14), .TOL(3), .TIMEOUT(1024)) dut_b (
    .clk(clk), .rst(rst), .mon_clk(mon_clk), .en(en), .clr(clr),
    .period(period_b), .valid(valid_b), .stopped(stopped_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_rise = 0;
  int stop_cyc = -1;
  int vcyc_log [0:255];
  int rise_log [0:255];
  logic prev_stopped = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid) begin
      if (n_valid < 256) vcyc_log[n_valid] = cyc;
      n_valid = n_valid + 1;
    end
    if (stopped && !prev_stopped) stop_cyc = cyc;
    prev_stopped = stopped;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; each mon_clk cycle starts with a rise and lasts per clk cycles.
  task automatic mon_run(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      mon_clk = 1'b1;
      if (n_rise < 256) rise_log[n_rise] = cyc;
      n_rise++;
      repeat (per / 2) @(negedge clk);
      mon_clk = 1'b0;
      repeat (per - per / 2) @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  int base, rb;

  initial begin
    @(negedge clk);
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);
    check("rst_stopped", stopped, 0);
    check("rst_err", err, 0);
    check("rst_valid_b", valid_b, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(negedge clk);

    // nominal 10-cycle mon_clk: first rise only arms
    base = n_valid; rb = n_rise;
    mon_run(10, 5);
    check("nom_valid_cnt", n_valid - base, 4);
    check("nom_first_valid_cyc", vcyc_log[base], rise_log[rb + 1] + 4);
    check("nom_period", period, 10);
    check("nom_err", err, 0);

    // slow 14-cycle clock sets err; clr clears it; coincident clr loses to a violation
    mon_run(14, 3);
    check("slow_period", period, 14);
    check("slow_err", err, 1);
    pulse_clr();
    check("clr_err", err, 0);
    mon_run(14, 1);
    check("reerr_period", period, 15);
    check("reerr_err", err, 1);
    fork
      mon_run(14, 1);
      begin
        repeat (3) @(negedge clk);
        pulse_clr();
      end
    join
    check("clr_coinc_period", period, 14);
    check("clr_coinc_err", err, 1);

    // stop: mon_clk held low
    base = n_valid;
    repeat (80) @(negedge clk);
    check("stop_level", stopped, 1);
    check("stop_latency", stop_cyc - rise_log[n_rise - 1], 68);
    check("stop_no_valid", n_valid - base, 0);

    // restart: first edge re-arms only
    mon_run(10, 1);
    check("restart_stopped", stopped, 0);
    check("restart_no_valid", n_valid - base, 0);
    mon_run(10, 1);
    check("restart_valid_cnt", n_valid - base, 1);
    check("restart_period", period, 10);
    check("restart_err_sticky", err, 1);

    // edge_det lands exactly on counter == TIMEOUT-1
    mon_run(64, 2);
    check("to_edge_period", period, 64);
    check("to_edge_stopped", stopped, 0);
    repeat (20) @(negedge clk);
    check("to_after_stopped", stopped, 1);
    mon_run(10, 2);

    // reset mid-period
    mon_clk = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_period", period, 0);
    check("midrst_valid", valid, 0);
    check("midrst_stopped", stopped, 0);
    check("midrst_err", err, 0);
    mon_clk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    base = n_valid; rb = n_rise;
    mon_run(10, 3);
    check("postrst_valid_cnt", n_valid - base, 2);
    check("postrst_first_cyc", vcyc_log[base], rise_log[rb + 1] + 4);

    // en dropped: period/err hold, no valid
    mon_run(14, 2);
    en = 1'b0;
    base = n_valid;
    mon_run(10, 3);
    check("dis_no_valid", n_valid - base, 0);
    check("dis_period_hold", period, 14);
    check("dis_err_hold", err, 1);
    check("dis_stopped", stopped, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    base = n_valid; rb = n_rise;
    mon_run(10, 3);
    check("reen_valid_cnt", n_valid - base, 2);
    check("reen_first_cyc", vcyc_log[base], rise_log[rb + 1] + 4);
    check("reen_period", period, 10);

    // saturation on the 4-bit instance with clamped upper bound
    mon_run(20, 2);
    pulse_clr();
    mon_run(20, 1);
    check("sat_main_period", period, 21);
    check("sat_main_err", err, 1);
    check("sat_b_period", period_b, 15);
    check("sat_b_err", err_b, 0);
    check("sat_b_stopped", stopped_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
